// File: rtl/note_label_pkg.sv
// Shared glyph constants, frame geometry and FSM state type for the note label sequencer.
// The flat-notation option (NOTE_LABEL_FLAT_EN) is resolved in note_glyph_map.
package note_label_pkg;

  localparam int GLYPH_W = 9;

  localparam logic [GLYPH_W-1:0] LETTER_A     = 9'h008;
  localparam logic [GLYPH_W-1:0] LETTER_B     = 9'h010;
  localparam logic [GLYPH_W-1:0] LETTER_C     = 9'h018;
  localparam logic [GLYPH_W-1:0] LETTER_D     = 9'h020;
  localparam logic [GLYPH_W-1:0] LETTER_E     = 9'h028;
  localparam logic [GLYPH_W-1:0] LETTER_F     = 9'h030;
  localparam logic [GLYPH_W-1:0] LETTER_G     = 9'h038;
  localparam logic [GLYPH_W-1:0] NUMBER_BASE  = 9'h180;
  localparam logic [GLYPH_W-1:0] SYMBOL_SPACE = 9'h100;
  localparam logic [GLYPH_W-1:0] SYMBOL_HASH  = 9'h118;
  localparam logic [GLYPH_W-1:0] SYMBOL_FLAT  = 9'h110;
  localparam logic [GLYPH_W-1:0] INVALID      = 9'h0C0;

  localparam int SEMITONES    = 12;
  localparam int CHARS_PER_CH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_EMIT,
    ST_DONE
  } state_t;

  function automatic logic [GLYPH_W-1:0] digit_glyph(input logic [3:0] d);
    return NUMBER_BASE + {2'b00, d, 3'b000};
  endfunction

endpackage

// File: rtl/note_glyph_map.sv
// Combinational map from (semitone, octave, valid, glyph index) to a font-ROM address.
// With NOTE_LABEL_FLAT_EN defined, accidentals are shown as the flat of the next letter.
module note_glyph_map
  import note_label_pkg::*;
#(
  parameter int OCT_W  = 4,
  parameter int ADDR_W = 9
) (
  input  logic [3:0]        semi,
  input  logic [OCT_W-1:0]  oct,
  input  logic              valid,
  input  logic [1:0]        k,
  output logic [ADDR_W-1:0] addr
);

  logic [GLYPH_W-1:0] letter_g;
  logic [GLYPH_W-1:0] acc_g;
  logic [GLYPH_W-1:0] digit_g;
  logic [GLYPH_W-1:0] glyph;

  always_comb begin
    letter_g = INVALID;
    acc_g    = SYMBOL_SPACE;
    case (semi)
      4'd0:  letter_g = LETTER_A;
      4'd1:  begin letter_g = LETTER_A; acc_g = SYMBOL_HASH; end
      4'd2:  letter_g = LETTER_B;
      4'd3:  letter_g = LETTER_C;
      4'd4:  begin letter_g = LETTER_C; acc_g = SYMBOL_HASH; end
      4'd5:  letter_g = LETTER_D;
      4'd6:  begin letter_g = LETTER_D; acc_g = SYMBOL_HASH; end
      4'd7:  letter_g = LETTER_E;
      4'd8:  letter_g = LETTER_F;
      4'd9:  begin letter_g = LETTER_F; acc_g = SYMBOL_HASH; end
      4'd10: letter_g = LETTER_G;
      4'd11: begin letter_g = LETTER_G; acc_g = SYMBOL_HASH; end
      default: letter_g = INVALID;
    endcase
`ifdef NOTE_LABEL_FLAT_EN
    // Octaves start at A, so G# wraps to Ab without touching the octave digit.
    if (acc_g == SYMBOL_HASH) begin
      acc_g    = SYMBOL_FLAT;
      letter_g = (letter_g == LETTER_G) ? LETTER_A : letter_g + 9'd8;
    end
`endif
    digit_g = (oct > OCT_W'(9)) ? INVALID : digit_glyph(oct[3:0]);
    if (!valid) begin
      letter_g = INVALID;
      acc_g    = INVALID;
      digit_g  = INVALID;
    end
    case (k)
      2'd0:    glyph = letter_g;
      2'd1:    glyph = acc_g;
      2'd2:    glyph = digit_g;
      default: glyph = SYMBOL_SPACE;
    endcase
  end

  assign addr = ADDR_W'(glyph);

endmodule

// File: rtl/note_label_seq.sv
// Snapshots NUM_CH note numbers and streams 4 glyph addresses per channel over valid/ready.
// Build option NOTE_LABEL_FLAT_EN selects flat instead of sharp accidentals (see note_glyph_map).
module note_label_seq
  import note_label_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int NOTE_W = 6,
  parameter int ADDR_W = 9
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [NUM_CH*NOTE_W-1:0]                   notes_in,
  input  logic                                       char_ready,
  output logic                                       char_valid,
  output logic [ADDR_W-1:0]                          char_addr,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] char_chan,
  output logic                                       char_last,
  output logic                                       busy,
  output logic                                       frame_done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OCT_W = (NOTE_W - 3 < 4) ? 4 : NOTE_W - 3;

  state_t              state_reg;
  logic [CH_W-1:0]     ch_reg;
  logic [1:0]          k_reg;
  logic [NOTE_W-1:0]   rem_reg;
  logic [OCT_W-1:0]    oct_reg;
  logic                valid_reg;

  logic [NOTE_W-1:0]   note_w   [NUM_CH];
  logic [NOTE_W-1:0]   snap_reg [NUM_CH];
  logic [CH_W-1:0]     ch_next;
  logic [1:0]          k_sel;
  logic [ADDR_W-1:0]   glyph_addr;
  logic                last_ch;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_snap
      assign note_w[gi] = notes_in[gi*NOTE_W +: NOTE_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          snap_reg[gi] <= '0;
        end else if (state_reg == ST_LOAD) begin
          snap_reg[gi] <= note_w[gi];
        end
      end
    end
  endgenerate

  assign ch_next = ch_reg + 1'b1;
  assign last_ch = (ch_reg == CH_W'(NUM_CH - 1));
  // Registered outputs are loaded one step ahead: glyph 0 on DIV exit, glyph k+1 on each transfer.
  assign k_sel   = (state_reg == ST_EMIT) ? k_reg + 2'd1 : 2'd0;

  note_glyph_map #(
    .OCT_W  (OCT_W),
    .ADDR_W (ADDR_W)
  ) u_map (
    .semi  (rem_reg[3:0]),
    .oct   (oct_reg),
    .valid (valid_reg),
    .k     (k_sel),
    .addr  (glyph_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ch_reg     <= '0;
      k_reg      <= '0;
      rem_reg    <= '0;
      oct_reg    <= '0;
      valid_reg  <= 1'b0;
      char_valid <= 1'b0;
      char_addr  <= '0;
      char_chan  <= '0;
      char_last  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LOAD;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Snapshot is being written this edge, so channel 0 seeds from the live input.
          ch_reg    <= '0;
          rem_reg   <= note_w[0] - 1'b1;
          oct_reg   <= OCT_W'(1);
          valid_reg <= (note_w[0] != '0);
          state_reg <= ST_DIV;
        end
        ST_DIV: begin
          if (valid_reg && (rem_reg >= NOTE_W'(SEMITONES))) begin
            rem_reg <= rem_reg - NOTE_W'(SEMITONES);
            oct_reg <= oct_reg + 1'b1;
          end else begin
            state_reg  <= ST_EMIT;
            k_reg      <= '0;
            char_valid <= 1'b1;
            char_addr  <= glyph_addr;
            char_chan  <= ch_reg;
            char_last  <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (char_ready) begin
            if (k_reg != 2'(CHARS_PER_CH - 1)) begin
              k_reg     <= k_reg + 2'd1;
              char_addr <= glyph_addr;
              char_last <= last_ch && (k_reg == 2'(CHARS_PER_CH - 2));
            end else begin
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              if (last_ch) begin
                state_reg  <= ST_DONE;
                frame_done <= 1'b1;
              end else begin
                ch_reg    <= ch_next;
                rem_reg   <= snap_reg[ch_next] - 1'b1;
                oct_reg   <= OCT_W'(1);
                valid_reg <= (snap_reg[ch_next] != '0);
                state_reg <= ST_DIV;
              end
            end
          end
        end
        ST_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: begin
          state_reg  <= ST_IDLE;
          char_valid <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
